// File: rtl/audio_in_capture.sv
// WM8731 ADC (I2S, codec master) receiver: oversampled deserializer feeding a show-ahead
// stereo frame FIFO, all in the CLOCK_50 domain.
module audio_in_capture #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          CLOCK_50,
    input  logic                          reset,
    input  logic                          AUD_BCLK,
    input  logic                          AUD_ADCLRCK,
    input  logic                          AUD_ADCDAT,
    input  logic                          enable,
    input  logic                          rd_en,
    input  logic                          clear_overflow,
    output logic [2*DATA_WIDTH-1:0]       rd_data,
    output logic                          fifo_empty,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level,
    output logic                          overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [BW-1:0] LastBit = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {StIdle, StAlign, StSkip, StShift, StWait} state_t;

    logic [1:0] bclk_sync, lr_sync, dat_sync;
    logic       bclk_hist, lr_hist;
    logic       bclk_rise, lr_rise, lr_fall;

    state_t                  state_q;
    logic                    chan_right_q;
    logic [BW-1:0]           bit_cnt_q;
    logic [DATA_WIDTH-2:0]   shift_q;
    logic [DATA_WIDTH-1:0]   left_hold_q;
    logic [DATA_WIDTH-1:0]   word;
    logic                    push_q;
    logic [2*DATA_WIDTH-1:0] push_frame_q;

    logic [2*DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]           count_q, count_d;
    logic                    full_q, empty_q, ovf_q;
    logic                    do_push, do_pop;

    // LRCK history only advances on BCLK rises, so its edges line up with a bit slot.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            bclk_sync <= '0;
            lr_sync   <= '0;
            dat_sync  <= '0;
            bclk_hist <= 1'b0;
            lr_hist   <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[0], AUD_BCLK};
            lr_sync   <= {lr_sync[0], AUD_ADCLRCK};
            dat_sync  <= {dat_sync[0], AUD_ADCDAT};
            bclk_hist <= bclk_sync[1];
            if (bclk_rise) lr_hist <= lr_sync[1];
        end
    end

    assign bclk_rise = bclk_sync[1] & ~bclk_hist;
    assign lr_rise   = bclk_rise & lr_sync[1] & ~lr_hist;
    assign lr_fall   = bclk_rise & ~lr_sync[1] & lr_hist;
    assign word      = {shift_q, dat_sync[1]};

    // The rise that reveals the LRCK edge carries the I2S delay bit, so SKIP lasts one cycle
    // and the MSB arrives on the following rise.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            chan_right_q <= 1'b0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            left_hold_q  <= '0;
            push_q       <= 1'b0;
            push_frame_q <= '0;
        end else begin
            push_q <= 1'b0;
            if (!enable) begin
                state_q <= StIdle;
            end else begin
                unique case (state_q)
                    StIdle: state_q <= StAlign;
                    StAlign: begin
                        if (lr_fall) begin
                            state_q      <= StSkip;
                            chan_right_q <= 1'b0;
                        end
                    end
                    StSkip: begin
                        state_q   <= StShift;
                        bit_cnt_q <= '0;
                    end
                    StShift: begin
                        if (lr_rise || lr_fall) begin
                            state_q <= StAlign;
                        end else if (bclk_rise) begin
                            shift_q   <= word[DATA_WIDTH-2:0];
                            bit_cnt_q <= bit_cnt_q + BW'(1);
                            if (bit_cnt_q == LastBit) begin
                                state_q <= StWait;
                                if (chan_right_q) begin
                                    push_q       <= 1'b1;
                                    push_frame_q <= {left_hold_q, word};
                                end else begin
                                    left_hold_q <= word;
                                end
                            end
                        end
                    end
                    StWait: begin
                        // Expected edge is the opposite of the current channel's level.
                        if (lr_rise || lr_fall) begin
                            if (lr_rise != chan_right_q) begin
                                state_q      <= StSkip;
                                chan_right_q <= lr_rise;
                            end else begin
                                state_q <= StAlign;
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign do_pop  = rd_en & ~empty_q;
    assign do_push = push_q & (~full_q | do_pop);

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (do_push) mem[wr_ptr_q] <= push_frame_q;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            full_q  <= (count_d == CW'(FIFO_DEPTH));
            empty_q <= (count_d == '0);
            if (push_q && full_q && !do_pop) begin
                ovf_q <= 1'b1;
            end else if (clear_overflow) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // Storage is not reset; masking keeps rd_data at zero whenever nothing is queued.
    assign rd_data    = empty_q ? '0 : mem[rd_ptr_q];
    assign fifo_empty = empty_q;
    assign fifo_full  = full_q;
    assign fill_level = count_q;
    assign overflow   = ovf_q;
endmodule

// File: tb/tb_audio_in_capture.sv
// Directed bench for audio_in_capture: drives an I2S ADC stream at CLOCK_50/16 and checks
// the frame FIFO against hand-computed frames.
module tb_audio_in_capture;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bclk = 1'b1;
    logic        lrck = 1'b1;
    logic        dat = 1'b0;
    logic        enable = 1'b0;
    logic        rd_en = 1'b0;
    logic        clr_ovf = 1'b0;
    logic [31:0] rd_data;
    logic        fifo_empty;
    logic        fifo_full;
    logic [3:0]  fill_level;
    logic        overflow;

    int n_cmp = 0;
    int n_err = 0;

    audio_in_capture #(.DATA_WIDTH(16), .FIFO_DEPTH(8)) dut (
        .CLOCK_50       (clk),
        .reset          (rst),
        .AUD_BCLK       (bclk),
        .AUD_ADCLRCK    (lrck),
        .AUD_ADCDAT     (dat),
        .enable         (enable),
        .rd_en          (rd_en),
        .clear_overflow (clr_ovf),
        .rd_data        (rd_data),
        .fifo_empty     (fifo_empty),
        .fifo_full      (fifo_full),
        .fill_level     (fill_level),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One BCLK period: LRCK/data change on the falling edge, the codec's launch edge.
    task automatic bit_period(input logic lr, input logic d);
        bclk = 1'b0;
        lrck = lr;
        dat  = d;
        repeat (8) @(negedge clk);
        bclk = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // Slot bit k=0 is the I2S delay bit; k=1..16 carry the word MSB first; rest pad with 0.
    task automatic send_bits(input logic lr, input logic [15:0] w, input int k0, input int k1);
        for (int k = k0; k < k1; k++) begin
            bit_period(lr, (k >= 1 && k <= 16) ? w[16-k] : 1'b0);
        end
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
        send_bits(1'b0, l, 0, 32);
        send_bits(1'b1, r, 0, 32);
    endtask

    task automatic pop();
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_q[$];

        repeat (3) @(negedge clk);
        check("reset_empty", fifo_empty, 1'b1);
        check("reset_full", fifo_full, 1'b0);
        check("reset_fill", fill_level, 4'd0);
        check("reset_ovf", overflow, 1'b0);
        check("reset_rdata", rd_data, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_empty", fifo_empty, 1'b1);

        // Basic frame, preceded by a right-slot preamble so the left slot starts on a fall.
        enable = 1'b1;
        send_bits(1'b1, 16'h0000, 0, 32);
        send_frame(16'h1234, 16'hABCD);
        check("basic_empty", fifo_empty, 1'b0);
        check("basic_fill", fill_level, 4'd1);
        check("basic_rdata", rd_data, 32'h1234ABCD);
        pop();
        check("basic_pop_empty", fifo_empty, 1'b1);
        check("basic_pop_fill", fill_level, 4'd0);

        // Alignment: enable rises mid right slot; that partial frame must not be pushed.
        enable = 1'b0;
        send_bits(1'b0, 16'h1111, 0, 32);
        send_bits(1'b1, 16'h2222, 0, 8);
        enable = 1'b1;
        send_bits(1'b1, 16'h2222, 8, 32);
        check("align_none", fill_level, 4'd0);
        send_frame(16'h3333, 16'h4444);
        check("align_fill", fill_level, 4'd1);
        check("align_rdata", rd_data, 32'h33334444);
        pop();

        // Overflow: nine frames with no reads.
        for (int i = 1; i <= 8; i++) send_frame(16'(i), 16'(i));
        check("ovf_full8", fifo_full, 1'b1);
        check("ovf_fill8", fill_level, 4'd8);
        check("ovf_clear8", overflow, 1'b0);
        send_frame(16'h0009, 16'h0009);
        check("ovf_set", overflow, 1'b1);
        check("ovf_fill9", fill_level, 4'd8);
        check("ovf_head", rd_data, 32'h00010001);
        @(negedge clk);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        check("ovf_cleared", overflow, 1'b0);

        // Full FIFO with a pop in exactly the push cycle (3 negedges after the final BCLK rise).
        send_bits(1'b0, 16'h000A, 0, 32);
        send_bits(1'b1, 16'h000A, 0, 16);
        bclk = 1'b0;
        lrck = 1'b1;
        dat  = 1'b0;
        repeat (8) @(negedge clk);
        bclk = 1'b1;
        repeat (3) @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        repeat (4) @(negedge clk);
        send_bits(1'b1, 16'h000A, 17, 32);
        check("pp_ovf", overflow, 1'b0);
        check("pp_fill", fill_level, 4'd8);
        check("pp_full", fifo_full, 1'b1);
        check("pp_head", rd_data, 32'h00020002);
        for (int i = 2; i <= 8; i++) exp_q.push_back({16'(i), 16'(i)});
        exp_q.push_back(32'h000A000A);
        foreach (exp_q[i]) begin
            check($sformatf("drain_%0d", i), rd_data, exp_q[i]);
            pop();
        end
        check("drain_empty", fifo_empty, 1'b1);
        check("drain_fill", fill_level, 4'd0);

        // Framing error: LRCK rises after only 10 bit periods of a left slot.
        send_bits(1'b0, 16'hFFFF, 0, 10);
        send_bits(1'b1, 16'h7777, 0, 32);
        check("frame_err_nopush", fill_level, 4'd0);
        send_frame(16'h5A5A, 16'hA5A5);
        check("frame_err_fill", fill_level, 4'd1);
        check("frame_err_rdata", rd_data, 32'h5A5AA5A5);
        pop();

        // Asynchronous reset during a right-word shift with three frames queued.
        send_frame(16'h1111, 16'h2222);
        send_frame(16'h3333, 16'h4444);
        send_frame(16'h5555, 16'h6666);
        check("rst_q3_fill", fill_level, 4'd3);
        send_bits(1'b0, 16'h7777, 0, 32);
        send_bits(1'b1, 16'h8888, 0, 8);
        #2 rst = 1'b1;
        #1;
        check("rst_empty", fifo_empty, 1'b1);
        check("rst_full", fifo_full, 1'b0);
        check("rst_fill", fill_level, 4'd0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_rdata", rd_data, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        send_bits(1'b1, 16'h8888, 8, 32);
        check("rst_nopartial", fill_level, 4'd0);
        send_frame(16'hC0DE, 16'hBEEF);
        check("rst_next_fill", fill_level, 4'd1);
        check("rst_next_rdata", rd_data, 32'hC0DEBEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
